interp_sample_feeder: RTL and testbench

INTERP_SAMPLE_FEEDER -- requirements
Module: interp_sample_feeder

---
 rtl/interp_sample_feeder.sv | 114 +++++++++++
 tb/tb_interp_sample_feeder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/interp_sample_feeder.sv
// interp_sample_feeder: buffers producer samples in a small FIFO and presents
// one held sample per reduced-rate tick to a downstream CIC interpolator.
// The reduced tick is derived from a full-rate tick by a phase counter; a pop
// on an empty FIFO holds the previous sample and raises a sticky underflow.
module interp_sample_feeder #(
    parameter int interpolation_factor = 8,
    parameter int num_bits             = 16,
    parameter int fifo_depth           = 4
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 tick_i,
    input  logic                                 enable_i,
    input  logic signed [num_bits-1:0]           sample_i,
    input  logic                                 valid_i,
    output logic                                 ready_o,
    output logic signed [num_bits-1:0]           signal_o,
    output logic                                 tick_reduced_o,
    output logic                                 underflow_o,
    input  logic                                 clear_underflow_i,
    output logic [$clog2(fifo_depth+1)-1:0]      fill_level_o
);

    localparam int phase_bits = $clog2(interpolation_factor);
    localparam int ptr_bits   = $clog2(fifo_depth);
    localparam int fill_bits  = $clog2(fifo_depth + 1);

    localparam logic [phase_bits-1:0] last_phase = phase_bits'(interpolation_factor - 1);
    localparam logic [fill_bits-1:0]  full_level = fill_bits'(fifo_depth);

    logic [phase_bits-1:0] phase;
    logic [ptr_bits-1:0]   rd_ptr;
    logic [ptr_bits-1:0]   wr_ptr;
    logic [fill_bits-1:0]  fill;
    logic [num_bits-1:0]   mem [fifo_depth];

    logic pop_event;
    logic pop_data;
    logic push;
    logic fifo_empty;

    assign fifo_empty = (fill == '0);
    assign pop_event  = tick_i & enable_i & (phase == last_phase);
    assign pop_data   = pop_event & ~fifo_empty;
    // ready depends only on the registered fill, so a pop from full frees the
    // slot visibly one clock later
    assign ready_o    = (fill < full_level);
    assign push       = valid_i & ready_o;

    assign fill_level_o = fill;

    // Phase counter: counts qualifying full-rate ticks, forced to 0 when disabled
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            phase <= '0;
        end else if (!enable_i) begin
            phase <= '0;
        end else if (tick_i) begin
            if (phase == last_phase) begin
                phase <= '0;
            end else begin
                phase <= phase + phase_bits'(1);
            end
        end
    end

    // FIFO pointers and fill level; push and pop together leave fill unchanged
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_bits'(1);
            end
            if (pop_data) begin
                rd_ptr <= rd_ptr + ptr_bits'(1);
            end
            case ({push, pop_data})
                2'b10:   fill <= fill + fill_bits'(1);
                2'b01:   fill <= fill - fill_bits'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Sample storage; contents are only meaningful below the fill level
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= sample_i;
        end
    end

    // Output stage: load head on pop, pulse the reduced tick, track underflow
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            signal_o       <= '0;
            tick_reduced_o <= 1'b0;
            underflow_o    <= 1'b0;
        end else begin
            tick_reduced_o <= pop_event;
            if (pop_data) begin
                signal_o <= mem[rd_ptr];
            end
            if (pop_event && fifo_empty) begin
                underflow_o <= 1'b1;
            end else if (clear_underflow_i) begin
                underflow_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_interp_sample_feeder.sv
// Self-checking bench for interp_sample_feeder (factor 8, 16-bit, depth 4).
// A queue-based reference model tracks expected outputs cycle by cycle.
module tb_interp_sample_feeder;

    localparam int FACTOR = 8;
    localparam int NB     = 16;
    localparam int DEPTH  = 4;

    logic                 clk_i = 1'b0;
    logic                 reset_i = 1'b0;
    logic                 tick_i = 1'b0;
    logic                 enable_i = 1'b0;
    logic signed [NB-1:0] sample_i = '0;
    logic                 valid_i = 1'b0;
    logic                 ready_o;
    logic signed [NB-1:0] signal_o;
    logic                 tick_reduced_o;
    logic                 underflow_o;
    logic                 clear_underflow_i = 1'b0;
    logic [2:0]           fill_level_o;

    interp_sample_feeder #(
        .interpolation_factor(FACTOR),
        .num_bits(NB),
        .fifo_depth(DEPTH)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .tick_i(tick_i),
        .enable_i(enable_i),
        .sample_i(sample_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .signal_o(signal_o),
        .tick_reduced_o(tick_reduced_o),
        .underflow_o(underflow_o),
        .clear_underflow_i(clear_underflow_i),
        .fill_level_o(fill_level_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic signed [NB-1:0] q[$];
    int                   qual_ticks = 0;
    logic signed [NB-1:0] m_sig = '0;
    bit                   m_uf = 1'b0;
    bit                   m_tick = 1'b0;
    int                   pulses = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ":signal"}, 32'(signal_o), 32'(m_sig));
        check({tag, ":tick"}, 32'(tick_reduced_o), 32'(m_tick));
        check({tag, ":uf"}, 32'(underflow_o), 32'(m_uf));
        check({tag, ":fill"}, 32'(fill_level_o), 32'(q.size()));
    endtask

    task automatic model_reset();
        q.delete();
        qual_ticks = 0;
        m_sig = '0;
        m_uf = 1'b0;
        m_tick = 1'b0;
    endtask

    // one clock: drive inputs, step the model, check after the edge
    task automatic cycle(input bit tk, input bit en, input bit vld,
                         input logic signed [NB-1:0] smp, input bit clr,
                         input string tag);
        bit exp_ready;
        bit pop;
        tick_i = tk;
        enable_i = en;
        valid_i = vld;
        sample_i = smp;
        clear_underflow_i = clr;
        exp_ready = (q.size() < DEPTH);
        #1;
        check({tag, ":ready"}, 32'(ready_o), 32'(exp_ready));
        pop = 1'b0;
        if (!en) begin
            qual_ticks = 0;
        end else if (tk) begin
            qual_ticks++;
            pop = (qual_ticks % FACTOR == 0);
        end
        if (pop && q.size() == 0) begin
            m_uf = 1'b1;
        end else if (clr) begin
            m_uf = 1'b0;
        end
        if (pop && q.size() > 0) begin
            m_sig = q.pop_front();
        end
        if (vld && exp_ready) begin
            q.push_back(smp);
        end
        m_tick = pop;
        if (pop) pulses++;
        @(posedge clk_i);
        #1;
        check_outputs(tag);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ":signal"}, 32'(signal_o), 32'h0);
        check({tag, ":tick"}, 32'(tick_reduced_o), 32'h0);
        check({tag, ":uf"}, 32'(underflow_o), 32'h0);
        check({tag, ":fill"}, 32'(fill_level_o), 32'h0);
        check({tag, ":ready"}, 32'(ready_o), 32'h1);
    endtask

    initial begin
        int guard;
        int first_pulse;

        // reset is asynchronous: outputs valid before any clock edge
        #1;
        check_reset_values("reset_init");
        model_reset();
        repeat (2) @(posedge clk_i);
        #4;
        reset_i = 1'b1;

        // continuous ticks: reduced tick every 8 clocks, first after 8th tick
        first_pulse = -1;
        for (int i = 0; i < 24; i++) begin
            cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, "rate");
            if (tick_reduced_o === 1'b1 && first_pulse < 0) first_pulse = i;
        end
        check("rate_first_pulse", 32'(first_pulse), 32'd7);
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b1, "rate_clr");

        // push 100, -5, 7 then tick: popped in order, fill 3->2->1->0
        cycle(1'b0, 1'b1, 1'b1, 16'sd100, 1'b0, "push3");
        cycle(1'b0, 1'b1, 1'b1, -16'sd5, 1'b0, "push3");
        cycle(1'b0, 1'b1, 1'b1, 16'sd7, 1'b0, "push3");
        check("push3_fill", 32'(fill_level_o), 32'd3);
        for (int i = 0; i < 24; i++) begin
            cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, "drain");
        end
        check("drain_last", 32'(signal_o), 32'(16'sd7));
        check("drain_fill", 32'(fill_level_o), 32'd0);

        // keep ticking past drain: hold last value, underflow sticky
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, "under");
        end
        check("under_hold", 32'(signal_o), 32'(16'sd7));
        check("under_set", 32'(underflow_o), 32'd1);
        guard = 0;
        while ((qual_ticks % FACTOR) != FACTOR - 1 && guard < 16) begin
            cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, "under_align");
            guard++;
        end
        cycle(1'b1, 1'b1, 1'b0, '0, 1'b1, "set_and_clr");
        check("set_and_clr_stays", 32'(underflow_o), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b1, "clr_only");
        check("clr_only_cleared", 32'(underflow_o), 32'd0);

        // valid held for 5 samples: 4 stored, 5th refused
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b1, NB'($urandom), 1'b0, "full");
        end
        check("full_ready", 32'(ready_o), 32'd0);
        check("full_fill", 32'(fill_level_o), 32'd4);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, 1'b1, NB'($urandom), 1'b0, "full_pop");
        end

        // bring fill to exactly 2 with the next tick being a pop
        guard = 0;
        while (!(q.size() == 2 && (qual_ticks % FACTOR) == FACTOR - 1) && guard < 64) begin
            if (q.size() < 2) cycle(1'b0, 1'b1, 1'b1, NB'($urandom), 1'b0, "f2_setup");
            else cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, "f2_setup");
            guard++;
        end
        check("f2_setup_reached", 32'(guard < 64), 32'd1);
        cycle(1'b1, 1'b1, 1'b1, 16'sh1234, 1'b0, "f2_pushpop");
        check("f2_fill_hold", 32'(fill_level_o), 32'd2);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, "f2_drain");
        end

        // reset asserted between edges with fill = 3
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b1, "pre_rst");
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b1, NB'($urandom), 1'b0, "pre_rst_fill");
        end
        cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, "pre_rst_tick");
        check("pre_rst_fill3", 32'(fill_level_o), 32'd3);
        #2;
        reset_i = 1'b0;
        #1;
        check_reset_values("reset_mid");
        model_reset();
        #10;
        reset_i = 1'b1;
        pulses = 0;
        for (int i = 0; i < FACTOR; i++) begin
            cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, "post_rst");
        end
        check("post_rst_pulse", 32'(pulses), 32'd1);
        check("post_rst_uf", 32'(underflow_o), 32'd1);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 15) != 0),
                  bit'($urandom_range(0, 3) == 0), NB'($urandom),
                  bit'($urandom_range(0, 7) == 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
